lector_sensor_spi: RTL and testbench

Sensor-side front end of the temperature monitor. It periodically reads a serial temperature sensor over a 3-wire SPI link (mode 0, MSB first) and checks each 16-bit frame. Valid frames are delivered as the signed 11-bit sample that the monitoring top consumes on `temp_entrada`. It also flags bad frames and a persistent sensor fault, which can feed the monitor's alert path.

---
 rtl/monitoreo_pkg.sv | 22 ++
 rtl/sincronizador_2ff.sv | 25 ++
 rtl/lector_sensor_spi.sv | 185 ++++++++++++++++++
 tb/tb_lector_sensor_spi.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/monitoreo_pkg.sv
// Shared types and constants for the temperature monitor front end.
package monitoreo_pkg;

   localparam int ANCHO_TEMP = 11;
   localparam int BITS_TRAMA = 16;

   localparam logic [2:0]            PATRON_VALIDO = 3'b111;
   localparam logic [BITS_TRAMA-1:0] TRAMA_AUSENTE = 16'hFFFF;

   typedef enum logic [1:0] {
      REPOSO,
      SELECCION,
      TRANSFERENCIA,
      FIN
   } estado_lector_t;

   // All-ones is rejected even though its tail matches: it means MISO is only pulled up.
   function automatic logic trama_es_valida(input logic [BITS_TRAMA-1:0] trama);
      return (trama[2:0] == PATRON_VALIDO) && (trama != TRAMA_AUSENTE);
   endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sincronizador_2ff (
   input  logic clk,
   input  logic arst_n,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sinc_q;

   // Two-stage capture; first stage may go metastable.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         meta_q <= 1'b0;
         sinc_q <= 1'b0;
      end else begin
         meta_q <= d;
         sinc_q <= meta_q;
      end
   end

   assign q = sinc_q;

endmodule

// File: rtl/lector_sensor_spi.sv
// Periodic 3-wire SPI reader for the temperature sensor with frame checking.
module lector_sensor_spi
   import monitoreo_pkg::*;
#(
   parameter int unsigned DIV_SCLK         = 4,
   parameter int unsigned PERIODO_MUESTREO = 1000,
   parameter int unsigned MAX_ERRORES      = 3
) (
   input  logic                         clk,
   input  logic                         arst_n,
   input  logic                         spi_miso,
   output logic                         spi_sclk,
   output logic                         spi_cs_n,
   output logic signed [ANCHO_TEMP-1:0] temp_salida,
   output logic                         temp_valida,
   output logic                         error_trama,
   output logic                         sensor_falla
);

   localparam int unsigned ANCHO_FASE = (DIV_SCLK > 1) ? $clog2(DIV_SCLK) : 1;
   localparam int unsigned ANCHO_PER  = (PERIODO_MUESTREO > 1) ? $clog2(PERIODO_MUESTREO) : 1;
   localparam int unsigned ANCHO_ERR  = $clog2(MAX_ERRORES + 1);

   localparam logic [ANCHO_FASE-1:0] FASE_FIN = ANCHO_FASE'(DIV_SCLK - 1);
   localparam logic [ANCHO_PER-1:0]  PER_FIN  = ANCHO_PER'(PERIODO_MUESTREO - 1);
   localparam logic [ANCHO_ERR-1:0]  ERR_MAX  = ANCHO_ERR'(MAX_ERRORES);

   if (DIV_SCLK < 4) begin : g_chk_div
      $error("DIV_SCLK must be at least 4");
   end
   if (PERIODO_MUESTREO < 33 * DIV_SCLK + 2) begin : g_chk_periodo
      $error("PERIODO_MUESTREO must be at least 33*DIV_SCLK+2");
   end
   if (MAX_ERRORES < 1) begin : g_chk_err
      $error("MAX_ERRORES must be at least 1");
   end

   estado_lector_t               estado_q, estado_d;
   logic [ANCHO_PER-1:0]         per_q;
   logic [ANCHO_FASE-1:0]        fase_q, fase_d;
   logic [3:0]                   bit_q, bit_d;
   logic [BITS_TRAMA-1:0]        trama_q, trama_d;
   logic [ANCHO_ERR-1:0]         errores_q, errores_d;
   logic                         sclk_q, sclk_d;
   logic                         cs_q, cs_d;
   logic signed [ANCHO_TEMP-1:0] temp_q, temp_d;
   logic                         valida_q, valida_d;
   logic                         error_q, error_d;
   logic                         falla_q, falla_d;
   logic                         miso_sinc;
   logic                         fin_periodo;

   sincronizador_2ff u_sinc_miso (
      .clk    (clk),
      .arst_n (arst_n),
      .d      (spi_miso),
      .q      (miso_sinc)
   );

   assign fin_periodo = (per_q == PER_FIN);

   // Free-running sample-period counter; never stalls on FSM state.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         per_q <= '0;
      end else if (fin_periodo) begin
         per_q <= '0;
      end else begin
         per_q <= per_q + 1'b1;
      end
   end

   // Next-state and registered-output logic for the conversion sequence.
   always_comb begin
      estado_d  = estado_q;
      fase_d    = fase_q;
      bit_d     = bit_q;
      trama_d   = trama_q;
      errores_d = errores_q;
      sclk_d    = sclk_q;
      cs_d      = cs_q;
      temp_d    = temp_q;
      valida_d  = 1'b0;
      error_d   = 1'b0;
      falla_d   = falla_q;

      case (estado_q)
         REPOSO: begin
            if (fin_periodo) begin
               estado_d = SELECCION;
               cs_d     = 1'b0;
               fase_d   = '0;
            end
         end

         SELECCION: begin
            if (fase_q == FASE_FIN) begin
               estado_d = TRANSFERENCIA;
               fase_d   = '0;
               sclk_d   = 1'b1;
               bit_d    = 4'd15;
            end else begin
               fase_d = fase_q + 1'b1;
            end
         end

         TRANSFERENCIA: begin
            if (fase_q != FASE_FIN) begin
               fase_d = fase_q + 1'b1;
            end else begin
               fase_d = '0;
               if (sclk_q) begin
                  // End of high phase: sample as SCLK falls.
                  sclk_d  = 1'b0;
                  trama_d = {trama_q[BITS_TRAMA-2:0], miso_sinc};
               end else if (bit_q != 4'd0) begin
                  bit_d  = bit_q - 4'd1;
                  sclk_d = 1'b1;
               end else begin
                  // Last low phase done: release CS and judge the frame in the same edge.
                  estado_d = FIN;
                  cs_d     = 1'b1;
                  if (trama_es_valida(trama_q)) begin
                     temp_d    = trama_q[BITS_TRAMA-1:BITS_TRAMA-ANCHO_TEMP];
                     valida_d  = 1'b1;
                     errores_d = '0;
                     falla_d   = 1'b0;
                  end else begin
                     error_d = 1'b1;
                     if (errores_q != ERR_MAX) begin
                        errores_d = errores_q + 1'b1;
                     end
                     falla_d = (errores_d == ERR_MAX);
                  end
               end
            end
         end

         FIN: begin
            estado_d = REPOSO;
         end

         default: begin
            estado_d = REPOSO;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         estado_q  <= REPOSO;
         fase_q    <= '0;
         bit_q     <= '0;
         trama_q   <= '0;
         errores_q <= '0;
         sclk_q    <= 1'b0;
         cs_q      <= 1'b1;
         temp_q    <= '0;
         valida_q  <= 1'b0;
         error_q   <= 1'b0;
         falla_q   <= 1'b0;
      end else begin
         estado_q  <= estado_d;
         fase_q    <= fase_d;
         bit_q     <= bit_d;
         trama_q   <= trama_d;
         errores_q <= errores_d;
         sclk_q    <= sclk_d;
         cs_q      <= cs_d;
         temp_q    <= temp_d;
         valida_q  <= valida_d;
         error_q   <= error_d;
         falla_q   <= falla_d;
      end
   end

   assign spi_sclk     = sclk_q;
   assign spi_cs_n     = cs_q;
   assign temp_salida  = temp_q;
   assign temp_valida  = valida_q;
   assign error_trama  = error_q;
   assign sensor_falla = falla_q;

endmodule

// File: tb/tb_lector_sensor_spi.sv
// Scoreboard bench for lector_sensor_spi with a behavioural sensor and frame model.
module tb_lector_sensor_spi;

   localparam int DIV = 4;
   localparam int PER = 1000;
   localparam int MAX = 3;

   logic               clk = 1'b0;
   logic               arst_n;
   logic               spi_miso;
   logic               spi_sclk;
   logic               spi_cs_n;
   logic signed [10:0] temp_salida;
   logic               temp_valida;
   logic               error_trama;
   logic               sensor_falla;

   lector_sensor_spi #(
      .DIV_SCLK         (DIV),
      .PERIODO_MUESTREO (PER),
      .MAX_ERRORES      (MAX)
   ) dut (
      .clk          (clk),
      .arst_n       (arst_n),
      .spi_miso     (spi_miso),
      .spi_sclk     (spi_sclk),
      .spi_cs_n     (spi_cs_n),
      .temp_salida  (temp_salida),
      .temp_valida  (temp_valida),
      .error_trama  (error_trama),
      .sensor_falla (sensor_falla)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit valida;
      int temp;
      bit falla;
   } esperado_t;

   esperado_t exp_q[$];

   int pasadas = 0;
   int total   = 0;

   // Reference model state
   int modelo_err  = 0;
   int modelo_temp = 0;

   int desde_ref  = 0;
   int viol_sclk  = 0;
   int viol_temp  = 0;

   task automatic chequear(input string nombre, input int actual, input int esperado);
      total++;
      if (actual == esperado) begin
         pasadas++;
      end else begin
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nombre, actual, esperado, $time);
      end
   endtask

   task automatic ciclo;
      @(posedge clk);
      #1;
      desde_ref++;
   endtask

   task automatic chequear_reset(input string etiqueta);
      chequear({etiqueta, "_cs_n"}, int'(spi_cs_n), 1);
      chequear({etiqueta, "_sclk"}, int'(spi_sclk), 0);
      chequear({etiqueta, "_temp"}, int'(temp_salida), 0);
      chequear({etiqueta, "_valida"}, int'(temp_valida), 0);
      chequear({etiqueta, "_error"}, int'(error_trama), 0);
      chequear({etiqueta, "_falla"}, int'(sensor_falla), 0);
   endtask

   // One conversion: wait for CS, play the sensor, optionally reset during bit 7.
   task automatic conversion(input logic [15:0] f, input bit abortar);
      logic [15:0] sh;
      bit          sclk_prev;
      int          subidas;
      int          n;
      esperado_t   e;
      bit          ok;

      while (spi_cs_n && desde_ref < 2 * PER) ciclo();
      chequear("espaciado_cs", desde_ref, PER);
      if (spi_cs_n) return;
      desde_ref = 0;

      ok = (f[2:0] == 3'b111) && (f != 16'hFFFF);
      if (ok) begin
         modelo_err  = 0;
         modelo_temp = int'($signed(f)) >>> 5;
      end else begin
         modelo_err = (modelo_err + 1 > MAX) ? MAX : modelo_err + 1;
      end
      e.valida = ok;
      e.temp   = modelo_temp;
      e.falla  = (modelo_err >= MAX);
      exp_q.push_back(e);

      sh        = f;
      spi_miso  = sh[15];
      sclk_prev = 1'b0;
      subidas   = 0;
      n         = 0;
      while (!spi_cs_n && n < 40 * DIV) begin
         ciclo();
         n++;
         if (spi_sclk && !sclk_prev) subidas++;
         if (!spi_sclk && sclk_prev) begin
            sh       = {sh[14:0], 1'b1};
            spi_miso = sh[15];
         end
         sclk_prev = spi_sclk;
         if (abortar && subidas == 9 && spi_sclk) begin
            arst_n = 1'b0;
            #1;
            chequear_reset("reset_medio");
            void'(exp_q.pop_back());
            modelo_err  = 0;
            modelo_temp = 0;
            spi_miso    = 1'b1;
            repeat (20) @(posedge clk);
            #1;
            arst_n    = 1'b1;
            desde_ref = 0;
            return;
         end
      end
      spi_miso = 1'b1;
      chequear("flancos_sclk", subidas, 16);
      chequear("duracion_cs", n, 33 * DIV);
   endtask

   // Monitor: pops the scoreboard whenever the DUT reports a frame result.
   initial begin : monitor
      int        ciclo_n   = 0;
      int        ciclo_cs  = 0;
      bit        cs_prev   = 1'b1;
      int        temp_prev = 0;
      esperado_t e;
      forever begin
         @(negedge clk);
         if (!arst_n) begin
            temp_prev = 0;
         end else begin
            if (cs_prev && !spi_cs_n) ciclo_cs = ciclo_n;
            if (spi_cs_n && spi_sclk) viol_sclk++;
            if (temp_valida || error_trama) begin
               if (exp_q.size() == 0) begin
                  chequear("pulso_inesperado", int'({temp_valida, error_trama}), 0);
               end else begin
                  e = exp_q.pop_front();
                  chequear("tipo_pulso", int'({temp_valida, error_trama}), e.valida ? 2 : 1);
                  chequear("temp_salida", int'(temp_salida), e.temp);
                  chequear("sensor_falla", int'(sensor_falla), int'(e.falla));
                  chequear("latencia", ciclo_n - ciclo_cs, 33 * DIV);
               end
            end else if (int'(temp_salida) != temp_prev) begin
               viol_temp++;
            end
            temp_prev = int'(temp_salida);
         end
         cs_prev = spi_cs_n;
         ciclo_n++;
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : estimulo
      logic [15:0] lista [8];
      logic [15:0] f;
      int          r;

      lista[0] = 16'h1907;
      lista[1] = 16'hFB07;
      lista[2] = 16'h1907;
      lista[3] = 16'h1900;
      lista[4] = 16'hFFFF;
      lista[5] = 16'hFFFF;
      lista[6] = 16'hFFFF;
      lista[7] = 16'h1907;

      arst_n   = 1'b0;
      spi_miso = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chequear_reset("reset");
      arst_n    = 1'b1;
      desde_ref = 0;

      for (int i = 0; i < 8; i++) conversion(lista[i], 1'b0);
      conversion(16'h1907, 1'b1);
      conversion(16'h1907, 1'b0);

      for (int i = 0; i < 8; i++) begin
         r = int'($urandom_range(0, 3));
         case (r)
            0: f = {5'($urandom), 6'($urandom), 2'($urandom), 3'b111};
            1: f = 16'hFFFF;
            2: f = 16'($urandom);
            default: f = {13'($urandom), 3'b111};
         endcase
         conversion(f, 1'b0);
      end

      repeat (20) ciclo();
      chequear("cola_vacia", exp_q.size(), 0);
      chequear("sclk_con_cs_alto", viol_sclk, 0);
      chequear("temp_estable", viol_temp, 0);

      $display("%0d/%0d checks passed", pasadas, total);
      $finish;
   end

endmodule
